// File: rtl/gaussian_line_ctrl.sv
// Line-buffer controller feeding a 3x3 Gaussian convolution datapath.
// Four rotating line buffers; emits one 72-bit window per cycle per line.
module gaussian_line_ctrl #(
    parameter int IMG_WIDTH = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_pixel_data,
    input  logic        i_pixel_data_valid,
    output logic        o_ready,
    output logic [71:0] o_pixel_data,
    output logic        o_pixel_data_valid,
    output logic        o_intr
);

    localparam int PW = $clog2(IMG_WIDTH);
    localparam int CW = $clog2(4 * IMG_WIDTH + 1);

    localparam logic [PW-1:0] LAST  = PW'(IMG_WIDTH - 1);
    localparam logic [PW:0]   LASTX = (PW + 1)'(IMG_WIDTH - 1);
    localparam logic [PW:0]   ONE   = (PW + 1)'(1);
    localparam logic [PW:0]   TWO   = (PW + 1)'(2);
    localparam logic [CW-1:0] FULL  = CW'(4 * IMG_WIDTH);
    localparam logic [CW-1:0] THREE = CW'(3 * IMG_WIDTH);
    localparam logic [CW-1:0] LINE  = CW'(IMG_WIDTH);
    localparam logic [CW-1:0] INC   = CW'(1);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [7:0]    r_mem [4][IMG_WIDTH];
    logic [PW-1:0] r_wr_pix;
    logic [1:0]    r_wr_buf;
    logic [PW-1:0] r_rd_pix;
    logic [1:0]    r_rd_buf;
    logic [CW-1:0] r_stored_cnt;

    logic          w_wr;
    logic          w_line_done;
    logic [CW-1:0] w_cnt_next;
    logic [PW:0]   w_x1;
    logic [PW:0]   w_x2;
    logic [PW-1:0] w_col [3];
    logic [71:0]   w_win;

    // A buffer is only released at line-done, so gating on the count
    // alone keeps writes away from the three lines being read.
    assign o_ready     = (r_stored_cnt < FULL);
    assign w_wr        = i_pixel_data_valid & o_ready;
    assign w_line_done = (r_state == READ) && (r_rd_pix == LAST);

    always_comb begin
        w_cnt_next = r_stored_cnt;
        if (w_wr)
            w_cnt_next = w_cnt_next + INC;
        if (w_line_done)
            w_cnt_next = w_cnt_next - LINE;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (r_stored_cnt >= THREE) w_next = READ;
            READ: if (r_rd_pix == LAST) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Columns past the right edge replicate the last pixel.
    always_comb begin
        w_x1     = {1'b0, r_rd_pix} + ONE;
        w_x2     = {1'b0, r_rd_pix} + TWO;
        w_col[0] = r_rd_pix;
        w_col[1] = (w_x1 > LASTX) ? LAST : w_x1[PW-1:0];
        w_col[2] = (w_x2 > LASTX) ? LAST : w_x2[PW-1:0];
    end

    always_comb begin
        w_win = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_win[(r*3+c)*8 +: 8] = r_mem[r_rd_buf + 2'(r)][w_col[c]];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr)
            r_mem[r_wr_buf][r_wr_pix] <= i_pixel_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_wr_pix     <= '0;
            r_wr_buf     <= '0;
            r_rd_pix     <= '0;
            r_rd_buf     <= '0;
            r_stored_cnt <= '0;
        end else begin
            r_state      <= w_next;
            r_stored_cnt <= w_cnt_next;
            if (w_wr) begin
                if (r_wr_pix == LAST) begin
                    r_wr_pix <= '0;
                    r_wr_buf <= r_wr_buf + 2'd1;
                end else begin
                    r_wr_pix <= r_wr_pix + 1'b1;
                end
            end
            if (r_state == IDLE) begin
                r_rd_pix <= '0;
            end else if (w_line_done) begin
                r_rd_pix <= '0;
                r_rd_buf <= r_rd_buf + 2'd1;
            end else begin
                r_rd_pix <= r_rd_pix + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pixel_data       <= '0;
            o_pixel_data_valid <= 1'b0;
            o_intr             <= 1'b0;
        end else begin
            o_pixel_data_valid <= (r_state == READ);
            o_intr             <= w_line_done;
            if (r_state == READ)
                o_pixel_data <= w_win;
        end
    end

endmodule

// File: tb/tb_gaussian_line_ctrl.sv
// Directed self-checking bench for gaussian_line_ctrl at IMG_WIDTH=8.
// Pixel value is line*16+col of the input raster.
module tb_gaussian_line_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  i_pixel_data = '0;
    logic        i_pixel_data_valid = 1'b0;
    logic        o_ready;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_intr;

    int nvec = 0;
    int nerr = 0;

    gaussian_line_ctrl #(.IMG_WIDTH(8)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_pixel_data       (i_pixel_data),
        .i_pixel_data_valid (i_pixel_data_valid),
        .o_ready            (o_ready),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .o_intr             (o_intr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] exp_win(input int top, input int x);
        logic [71:0] w;
        int col;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                col = (x + c > 7) ? 7 : x + c;
                w[(r*3+c)*8 +: 8] = 8'((top + r) * 16 + col);
            end
        end
        return w;
    endfunction

    function automatic logic [7:0] pix(input int n);
        return 8'((n / 8) * 16 + (n % 8));
    endfunction

    task automatic do_reset;
        i_pixel_data_valid = 1'b0;
        i_pixel_data = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        rst = 1'b1;
        #1;
        nvec++;
        if (o_pixel_data !== 72'h0) begin
            nerr++;
            $display("FAIL reset_data got %h want 0", o_pixel_data);
        end
        nvec++;
        if (o_pixel_data_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_valid got %b want 0", o_pixel_data_valid);
        end
        nvec++;
        if (o_intr !== 1'b0) begin
            nerr++;
            $display("FAIL reset_intr got %b want 0", o_intr);
        end
        nvec++;
        if (o_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_ready got %b want 1", o_ready);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic run_fill(input string tag);
        for (int p = 0; p < 24; p++) begin
            i_pixel_data = pix(p);
            i_pixel_data_valid = 1'b1;
            nvec++;
            if (o_ready !== 1'b1) begin
                nerr++;
                $display("FAIL %s_ready p=%0d got %b want 1", tag, p, o_ready);
            end
            tick();
            nvec++;
            if (o_pixel_data_valid !== 1'b0) begin
                nerr++;
                $display("FAIL %s_early_valid p=%0d got 1 want 0", tag, p);
            end
        end
        i_pixel_data_valid = 1'b0;
        tick();
        nvec++;
        if (o_pixel_data_valid !== 1'b0) begin
            nerr++;
            $display("FAIL %s_latency got 1 want 0 at N+1", tag);
        end
        for (int x = 0; x < 8; x++) begin
            tick();
            nvec++;
            if (o_pixel_data_valid !== 1'b1) begin
                nerr++;
                $display("FAIL %s_valid x=%0d got 0 want 1", tag, x);
            end
            nvec++;
            if (o_pixel_data !== exp_win(0, x)) begin
                nerr++;
                $display("FAIL %s_win x=%0d got %h want %h",
                         tag, x, o_pixel_data, exp_win(0, x));
            end
            nvec++;
            if (o_intr !== (x == 7)) begin
                nerr++;
                $display("FAIL %s_intr x=%0d got %b want %b", tag, x, o_intr, x == 7);
            end
            if (x == 0) begin
                nvec++;
                if (o_pixel_data !== 72'h22_21_20_12_11_10_02_01_00) begin
                    nerr++;
                    $display("FAIL %s_first got %h want 222120121110020100", tag, o_pixel_data);
                end
            end
            if (x == 6) begin
                nvec++;
                if (o_pixel_data !== 72'h27_27_26_17_17_16_07_07_06) begin
                    nerr++;
                    $display("FAIL %s_x6 got %h want 272726171716070706", tag, o_pixel_data);
                end
            end
            if (x == 7) begin
                nvec++;
                if (o_pixel_data !== 72'h27_27_27_17_17_17_07_07_07) begin
                    nerr++;
                    $display("FAIL %s_x7 got %h want 272727171717070707", tag, o_pixel_data);
                end
            end
        end
        tick();
        nvec++;
        if (o_pixel_data_valid !== 1'b0 || o_intr !== 1'b0) begin
            nerr++;
            $display("FAIL %s_after got v=%b i=%b want 0 0", tag, o_pixel_data_valid, o_intr);
        end
        nvec++;
        if (o_pixel_data !== 72'h27_27_27_17_17_17_07_07_07) begin
            nerr++;
            $display("FAIL %s_hold got %h want 272727171717070707", tag, o_pixel_data);
        end
    endtask

    task automatic test_fill;
        do_reset();
        run_fill("fill");
    endtask

    task automatic test_back_to_back;
        int  acc;
        int  nwin;
        int  nintr;
        int  last;
        int  oline;
        int  ocol;
        bit  took;
        do_reset();
        acc = 0; nwin = 0; nintr = 0; last = 0; oline = 0; ocol = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (acc == 96 && nwin == 80) break;
            i_pixel_data_valid = (acc < 96);
            i_pixel_data = pix(acc);
            took = i_pixel_data_valid && o_ready;
            tick();
            if (took) begin
                acc++;
                if (acc == 31) begin
                    nvec++;
                    if (o_ready !== 1'b1) begin
                        nerr++;
                        $display("FAIL bp_ready31 got 0 want 1");
                    end
                end
                if (acc == 32) begin
                    nvec++;
                    if (o_ready !== 1'b0) begin
                        nerr++;
                        $display("FAIL bp_ready32 got 1 want 0");
                    end
                end
            end
            if (o_pixel_data_valid === 1'b1) begin
                nvec++;
                if (nwin >= 80) begin
                    nerr++;
                    $display("FAIL bp_extra_window got window %0d want none", nwin);
                end else if (o_pixel_data !== exp_win(oline, ocol)) begin
                    nerr++;
                    $display("FAIL bp_win l=%0d x=%0d got %h want %h",
                             oline, ocol, o_pixel_data, exp_win(oline, ocol));
                end
                if (oline == 1 && ocol == 0) begin
                    nvec++;
                    if (o_pixel_data !== 72'h32_31_30_22_21_20_12_11_10) begin
                        nerr++;
                        $display("FAIL bp_line1 got %h want 323130222120121110", o_pixel_data);
                    end
                end
                nvec++;
                if (o_intr !== (ocol == 7)) begin
                    nerr++;
                    $display("FAIL bp_intr l=%0d x=%0d got %b want %b",
                             oline, ocol, o_intr, ocol == 7);
                end
                if (o_intr === 1'b1) begin
                    nintr++;
                    if (nintr == 1) begin
                        nvec++;
                        if (o_ready !== 1'b1) begin
                            nerr++;
                            $display("FAIL bp_ready_return got 0 want 1");
                        end
                    end else begin
                        nvec++;
                        if (cyc - last < 9) begin
                            nerr++;
                            $display("FAIL bp_intr_gap got %0d want >=9", cyc - last);
                        end
                    end
                    last = cyc;
                end
                nwin++;
                if (ocol == 7) begin
                    ocol = 0;
                    oline++;
                end else begin
                    ocol++;
                end
            end else begin
                nvec++;
                if (o_intr !== 1'b0) begin
                    nerr++;
                    $display("FAIL bp_stray_intr got 1 want 0");
                end
            end
        end
        i_pixel_data_valid = 1'b0;
        nvec++;
        if (acc !== 96) begin
            nerr++;
            $display("FAIL bp_accepts got %0d want 96", acc);
        end
        nvec++;
        if (nwin !== 80) begin
            nerr++;
            $display("FAIL bp_windows got %0d want 80", nwin);
        end
        nvec++;
        if (nintr !== 10) begin
            nerr++;
            $display("FAIL bp_intr_count got %0d want 10", nintr);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            nvec++;
            if (o_pixel_data_valid !== 1'b0) begin
                nerr++;
                $display("FAIL bp_drain got 1 want 0");
            end
        end
    endtask

    task automatic test_simul;
        do_reset();
        for (int p = 0; p < 25; p++) begin
            i_pixel_data = pix(p);
            i_pixel_data_valid = 1'b1;
            tick();
            nvec++;
            if (o_pixel_data_valid !== 1'b0) begin
                nerr++;
                $display("FAIL sim_early p=%0d got 1 want 0", p);
            end
        end
        i_pixel_data_valid = 1'b0;
        for (int x = 0; x < 7; x++) begin
            tick();
            nvec++;
            if (o_pixel_data_valid !== 1'b1 || o_pixel_data !== exp_win(0, x)) begin
                nerr++;
                $display("FAIL sim_win x=%0d got v=%b %h want v=1 %h",
                         x, o_pixel_data_valid, o_pixel_data, exp_win(0, x));
            end
        end
        i_pixel_data = pix(25);
        i_pixel_data_valid = 1'b1;
        nvec++;
        if (o_ready !== 1'b1) begin
            nerr++;
            $display("FAIL sim_ready got 0 want 1");
        end
        tick();
        i_pixel_data_valid = 1'b0;
        nvec++;
        if (o_pixel_data_valid !== 1'b1 || o_intr !== 1'b1) begin
            nerr++;
            $display("FAIL sim_last got v=%b i=%b want 1 1", o_pixel_data_valid, o_intr);
        end
        nvec++;
        if (dut.r_stored_cnt !== 6'd18) begin
            nerr++;
            $display("FAIL sim_cnt got %0d want 18", dut.r_stored_cnt);
        end
        for (int p = 26; p < 32; p++) begin
            i_pixel_data = pix(p);
            i_pixel_data_valid = 1'b1;
            tick();
            nvec++;
            if (o_pixel_data_valid !== 1'b0) begin
                nerr++;
                $display("FAIL sim_refill p=%0d got 1 want 0", p);
            end
        end
        i_pixel_data_valid = 1'b0;
        tick();
        nvec++;
        if (o_pixel_data_valid !== 1'b0) begin
            nerr++;
            $display("FAIL sim_gap got 1 want 0");
        end
        for (int x = 0; x < 8; x++) begin
            tick();
            nvec++;
            if (o_pixel_data_valid !== 1'b1 || o_pixel_data !== exp_win(1, x)) begin
                nerr++;
                $display("FAIL sim_line1 x=%0d got v=%b %h want v=1 %h",
                         x, o_pixel_data_valid, o_pixel_data, exp_win(1, x));
            end
            nvec++;
            if (o_intr !== (x == 7)) begin
                nerr++;
                $display("FAIL sim_line1_intr x=%0d got %b want %b", x, o_intr, x == 7);
            end
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        for (int p = 0; p < 24; p++) begin
            i_pixel_data = pix(p);
            i_pixel_data_valid = 1'b1;
            tick();
        end
        i_pixel_data_valid = 1'b0;
        tick();
        for (int x = 0; x < 4; x++) begin
            tick();
            nvec++;
            if (o_pixel_data_valid !== 1'b1) begin
                nerr++;
                $display("FAIL ar_pre x=%0d got 0 want 1", x);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        nvec++;
        if (o_pixel_data !== 72'h0 || o_pixel_data_valid !== 1'b0) begin
            nerr++;
            $display("FAIL ar_out got v=%b %h want 0 0", o_pixel_data_valid, o_pixel_data);
        end
        nvec++;
        if (o_intr !== 1'b0 || o_ready !== 1'b1) begin
            nerr++;
            $display("FAIL ar_flags got i=%b r=%b want 0 1", o_intr, o_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        run_fill("rerun");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_back_to_back();
        test_simul();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/gaussian_line_ctrl.md
Name: gaussian_line_ctrl

Overview:
Line-buffer controller that sits upstream of the 3x3 Gaussian convolution datapath. It accepts a raster pixel stream and stores it in four rotating line buffers. Once three lines are resident, it emits one 72-bit 3x3 window per cycle for a full line, then interrupts the host (PYNQ PS) to signal that a line has been consumed. It also back-pressures the upstream source when all four buffers hold unconsumed data.

Parameters:
IMG_WIDTH, 512, pixels per image line (>=3); depth of each line buffer.

Ports:
i_clk  input  1  system clock, all logic rising-edge.
i_rst  input  1  asynchronous, active-high reset.
i_pixel_data  input  8  incoming pixel, raster order.
i_pixel_data_valid  input  1  upstream pixel valid.
o_ready  output  1  high when a pixel can be accepted; a write occurs when i_pixel_data_valid & o_ready.
o_pixel_data  output  72  3x3 window to the convolution datapath.
o_pixel_data_valid  output  1  window valid, one cycle per window.
o_intr  output  1  one-cycle pulse at the end of each output line.

Behaviour:
- Reset is asynchronous and active-high.
  - Reset values: o_pixel_data=0, o_pixel_data_valid=0, o_intr=0, o_ready=1.
  - Reset clears wr_pix, wr_buf, rd_pix, rd_buf and stored_cnt, and forces the FSM to IDLE.
  - Line-buffer RAM contents are not cleared.
  - Reset mid-line discards all in-flight state; the next accepted pixel goes to buffer 0, column 0.
- Storage: 4 buffers x IMG_WIDTH x 8 bit.
- Write side:
  - An accepted pixel is stored at buffer wr_buf, column wr_pix.
  - wr_pix increments and wraps at IMG_WIDTH-1 to 0.
  - On that wrap, wr_buf increments mod 4.
- stored_cnt (width clog2(4*IMG_WIDTH+1)):
  - +1 per accepted write.
  - -IMG_WIDTH on a line-done event.
  - Both events in the same cycle: net +1-IMG_WIDTH.
  - Never exceeds 4*IMG_WIDTH and never goes negative.
- o_ready is combinational: stored_cnt < 4*IMG_WIDTH.
  - Buffer rd_buf is freed only at line-done, so a write can never overwrite a line still in use.
- FSM states: IDLE and READ.
  - IDLE -> READ when stored_cnt >= 3*IMG_WIDTH, evaluated on the registered count. Start rd_pix at 0.
  - READ: one window read per cycle, rd_pix increments.
  - When rd_pix == IMG_WIDTH-1: that read is the last of the line. This is the line-done event: rd_buf increments mod 4 and the FSM returns to IDLE.
  - IDLE -> READ re-entry needs at least one IDLE cycle. Back-to-back lines are therefore separated by exactly one idle cycle when data is available.
- Window assembly for a read at column x:
  - Top line = rd_buf, middle = rd_buf+1, bottom = rd_buf+2, all mod 4.
  - Columns used are x, x+1, x+2. Any column > IMG_WIDTH-1 clamps to IMG_WIDTH-1 (right-edge replication).
  - Byte order: [7:0]=top[x], [15:8]=top[x+1], [23:16]=top[x+2], [31:24]=mid[x], ..., [71:64]=bot[x+2].
- Latency: o_pixel_data and o_pixel_data_valid are registered, valid the cycle after the read cycle.
  - o_pixel_data holds its last value when valid is low.
- o_intr is asserted in the same cycle as o_pixel_data_valid for the window at column IMG_WIDTH-1.
- A write to buffer wr_buf concurrent with reads of the other three buffers is legal and must not disturb read data.

Test Plan:
All tests use IMG_WIDTH=8. Pixel value = line*16+col, where line is the input line index.
- Fill 24 pixels back-to-back.
  - Nothing valid through the 23rd.
  - Edge N accepts the 24th; o_pixel_data_valid is high after edge N+2 for 8 consecutive cycles.
  - First window = 0x22_21_20_12_11_10_02_01_00.
  - o_intr is high only with the 8th window.
- Right-edge clamp: window x=7 of the first line = 0x27_27_27_17_17_17_07_07_07; x=6 = 0x27_27_26_17_17_16_07_07_06.
- Backpressure: hold i_pixel_data_valid=1 continuously.
  - o_ready falls after the 32nd accept (stored_cnt=32).
  - o_ready returns high the cycle after line-done, when stored_cnt=24.
  - Second line window x=0 = 0x32_31_30_22_21_20_12_11_10.
  - No pixel is lost or duplicated; check with a scoreboard over 10 lines.
- Buffer wrap: stream 12 lines.
  - Windows continue correctly after rd_buf wraps 3->0.
  - 10 o_intr pulses, each separated by at least 9 cycles.
- Simultaneous write and line-done: arrange an accept in the cycle of the 8th read. stored_cnt goes from 25 to 18, with no stall or overflow.
- Async reset asserted mid-READ (after 4 windows), no clock edge required.
  - All outputs go to reset values immediately.
  - After release, a fresh 24-pixel fill reproduces the first-test results exactly.
